matrix_sender: RTL

Downstream UART formatting stage for the matrix generator, input and display controllers. It accepts one command at a time: a signed matrix element, a bare newline, or a fixed mode banner string. It converts the command into an ASCII byte stream and feeds the byte-wide UART transmitter one byte at a time. It pulses `done` once the final byte has left the transmitter.

---
 rtl/matrix_sender.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_sender.sv
// matrix_sender: turns one command (signed element, bare newline or mode
// banner) into an ASCII byte stream and feeds a byte-wide UART TX one byte
// at a time, pulsing done after the last byte has left the transmitter.
// Build option: define SENDER_CRLF_EN for CR LF line endings, otherwise LF.
// BUF_DEPTH must be at least 13 (sign + 10 digits + CR LF).
module matrix_sender #(
    parameter int BUF_DEPTH = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              str,
    input  logic [2:0]        str_id,
    input  logic [DATA_W-1:0] data,
    input  logic              is_last_col,
    input  logic              newline_only,
    output logic              ready,
    output logic              done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

`ifdef SENDER_CRLF_EN
    localparam int         NL_LEN   = 2;
    localparam logic [7:0] NL_FIRST = 8'h0D;
`else
    localparam int         NL_LEN   = 1;
    localparam logic [7:0] NL_FIRST = 8'h0A;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUILD,
        S_CONV,
        S_EMIT,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_FINISH
    } state_t;

    // Decimal weights for the digit loop, 10^0 .. 10^9.
    function automatic logic [DATA_W:0] pow10(input logic [3:0] idx);
        logic [63:0] p;
        case (idx)
            4'd0:    p = 64'd1;
            4'd1:    p = 64'd10;
            4'd2:    p = 64'd100;
            4'd3:    p = 64'd1000;
            4'd4:    p = 64'd10000;
            4'd5:    p = 64'd100000;
            4'd6:    p = 64'd1000000;
            4'd7:    p = 64'd10000000;
            4'd8:    p = 64'd100000000;
            4'd9:    p = 64'd1000000000;
            default: p = 64'd1;
        endcase
        return p[DATA_W:0];
    endfunction

    // Character count of each banner, terminator excluded.
    function automatic int banner_len(input logic [2:0] id);
        case (id)
            3'd0:    return 10;
            3'd1:    return 8;
            3'd2:    return 9;
            3'd3:    return 9;
            default: return 3;
        endcase
    endfunction

    // Byte idx of the banner for id, including the line terminator.
    function automatic logic [7:0] banner_byte(input logic [2:0] id, input int idx);
        logic [79:0] s;
        int          len;
        len = banner_len(id);
        case (id)
            3'd0:    s = "MODE-INPUT";
            3'd1:    s = {16'h0, "MODE-GEN"};
            3'd2:    s = {8'h0, "MODE-CALC"};
            3'd3:    s = {8'h0, "MODE-SHOW"};
            default: s = {56'h0, "ERR"};
        endcase
        if (idx < len)
            return s[8*(len-1-idx) +: 8];
        else if (idx == len)
            return NL_FIRST;
        else if (NL_LEN == 2 && idx == len + 1)
            return 8'h0A;
        else
            return 8'h00;
    endfunction

    state_t             state, state_next;
    logic [7:0]         byte_buf [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_p1, wr_ptr_p1, wr_ptr_p2;
    logic [DATA_W-1:0]  data_q;
    logic               last_q;
    logic [DATA_W:0]    mag;
    logic [DATA_W:0]    data_ext;
    logic [3:0]         pidx;
    logic [3:0]         cnt;
    logic               started;
    logic               sub_ok;
    logic               digit_emit;

    assign rd_ptr_p1 = rd_ptr + 1'b1;
    assign wr_ptr_p1 = wr_ptr + 1'b1;
    assign wr_ptr_p2 = wr_ptr + 2'd2;
    assign data_ext  = {data_q[DATA_W-1], data_q};

    // Another subtraction fits at the current power of ten.
    assign sub_ok = (mag >= pow10(pidx));
    // Leading zeros are dropped, but the units digit always goes out.
    assign digit_emit = (cnt != 4'd0) || started || (pidx == 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (str)                        state_next = S_EMIT;
                else if (start && newline_only) state_next = S_EMIT;
                else if (start)                 state_next = S_BUILD;
            end
            S_BUILD:     state_next = S_CONV;
            S_CONV:      if (!sub_ok && pidx == 4'd0) state_next = S_EMIT;
            S_EMIT:      if (!tx_busy) state_next = S_WAIT_RISE;
            S_WAIT_RISE: if (tx_busy) state_next = S_WAIT_FALL;
            S_WAIT_FALL: begin
                if (!tx_busy)
                    state_next = (rd_ptr_p1 < wr_ptr) ? S_EMIT : S_FINISH;
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    // Byte buffer, digit conversion and TX drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) byte_buf[i] <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            mag      <= '0;
            pidx     <= 4'd0;
            cnt      <= 4'd0;
            started  <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    rd_ptr <= '0;
                    if (str) begin
                        for (int i = 0; i < BUF_DEPTH; i++)
                            byte_buf[i] <= banner_byte(str_id, i);
                        wr_ptr <= PTR_W'(banner_len(str_id) + NL_LEN);
                    end else if (start && newline_only) begin
                        byte_buf[0] <= NL_FIRST;
                        if (NL_LEN == 2) byte_buf[1] <= 8'h0A;
                        wr_ptr <= PTR_W'(NL_LEN);
                    end else if (start) begin
                        data_q <= data;
                        last_q <= is_last_col;
                    end
                end
                S_BUILD: begin
                    // Negation in DATA_W+1 bits keeps the most negative value exact.
                    if (data_q[DATA_W-1]) begin
                        byte_buf[0] <= 8'h2D;
                        wr_ptr      <= PTR_W'(1);
                        mag         <= ~data_ext + 1'b1;
                    end else begin
                        wr_ptr      <= '0;
                        mag         <= data_ext;
                    end
                    pidx    <= 4'd9;
                    cnt     <= 4'd0;
                    started <= 1'b0;
                end
                S_CONV: begin
                    if (sub_ok) begin
                        mag <= mag - pow10(pidx);
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= 4'd0;
                        if (digit_emit) begin
                            byte_buf[wr_ptr] <= {4'h3, cnt};
                            started          <= 1'b1;
                        end
                        if (pidx != 4'd0) begin
                            pidx <= pidx - 1'b1;
                            if (digit_emit) wr_ptr <= wr_ptr_p1;
                        end else begin
                            // Units digit sits at wr_ptr; separator follows it.
                            if (last_q) begin
                                byte_buf[wr_ptr_p1] <= NL_FIRST;
                                if (NL_LEN == 2) byte_buf[wr_ptr_p2] <= 8'h0A;
                                wr_ptr <= wr_ptr + PTR_W'(NL_LEN + 1);
                            end else begin
                                byte_buf[wr_ptr_p1] <= 8'h20;
                                wr_ptr <= wr_ptr_p2;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (!tx_busy) begin
                        tx_data  <= byte_buf[rd_ptr];
                        tx_start <= 1'b1;
                    end
                end
                S_WAIT_FALL: begin
                    if (!tx_busy) rd_ptr <= rd_ptr_p1;
                end
                S_FINISH: begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
